// File: rtl/mul_pkg.sv
// mul_pkg: shared widths, default op record and operand extension for the multiply-add pipe
//   MUL_W_DEFAULT / RES_W_DEFAULT / TAG_W_DEFAULT : default operand, result and tag widths
//   EXT_W_MAX  : widest value ext_operand can extend
//   mul_op_t   : op record {a, b, is_signed, tag} at default widths
//   ext_operand: zero- or sign-extend the low `width` bits of a value to EXT_W_MAX bits
package mul_pkg;
  localparam int MUL_W_DEFAULT = 54;
  localparam int RES_W_DEFAULT = 105;
  localparam int TAG_W_DEFAULT = 4;
  localparam int EXT_W_MAX = 256;
  typedef struct packed {
    logic [MUL_W_DEFAULT-1:0] a;
    logic [MUL_W_DEFAULT-1:0] b;
    logic                     is_signed;
    logic [TAG_W_DEFAULT-1:0] tag;
  } mul_op_t;
  function automatic logic [EXT_W_MAX-1:0] ext_operand(
    input logic [EXT_W_MAX-1:0] value,
    input int unsigned          width,
    input logic                 is_signed
  );
    logic [EXT_W_MAX-1:0] keep;
    logic                 msb;
    keep = ~({EXT_W_MAX{1'b1}} << width);
    // keep ^ (keep >> 1) isolates bit width-1, the operand's sign bit
    msb = |(value & (keep ^ (keep >> 1)));
    return (value & keep) | ({EXT_W_MAX{is_signed & msb}} & ~keep);
  endfunction
endpackage

// File: rtl/mul_add_pipe_if.sv
// mul_add_pipe_if: op/result bundle of the multiply-add pipe
//   master drives: in_valid, latch_a, a, latch_b, b, is_signed, tag, c, stall, flush
//   slave  drives: c_req, out_valid, out_tag, result
interface mul_add_pipe_if
  import mul_pkg::*;
#(
  parameter int W     = MUL_W_DEFAULT,
  parameter int RES_W = RES_W_DEFAULT,
  parameter int TAG_W = TAG_W_DEFAULT
);
  logic             in_valid;
  logic             latch_a;
  logic [W-1:0]     a;
  logic             latch_b;
  logic [W-1:0]     b;
  logic             is_signed;
  logic [TAG_W-1:0] tag;
  logic [RES_W-1:0] c;
  logic             stall;
  logic             flush;
  logic             c_req;
  logic             out_valid;
  logic [TAG_W-1:0] out_tag;
  logic [RES_W-1:0] result;
  modport master (
    output in_valid, latch_a, a, latch_b, b, is_signed, tag, c, stall, flush,
    input  c_req, out_valid, out_tag, result
  );
  modport slave (
    input  in_valid, latch_a, a, latch_b, b, is_signed, tag, c, stall, flush,
    output c_req, out_valid, out_tag, result
  );
endinterface

// File: rtl/mul_pipe_stage.sv
// mul_pipe_stage: one pipeline register, valid + payload, with stall and flush
//   clock, reset       : clock, synchronous active-high reset
//   stall, flush       : hold everything / drop valid (flush wins)
//   in_valid, in_data  : upstream stage
//   out_valid, out_data: this stage
module mul_pipe_stage #(
  parameter int PW = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  output logic [PW-1:0] out_data
);
  // payload only loads behind a valid op so bubbles leave the data regs quiet
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!stall) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end
endmodule

// File: rtl/mul_add_pipe.sv
// mul_add_pipe: pipelined fused multiply-add, result = (a*b + c) mod 2^RES_W
//   clock, reset : sole clock, synchronous active-high reset
//   io (slave)   : in_valid/latch_a/a/latch_b/b/is_signed/tag in, c addend at stage C_STAGE,
//                  stall/flush controls, c_req/out_valid/out_tag/result out
module mul_add_pipe
  import mul_pkg::*;
#(
  parameter int W       = MUL_W_DEFAULT,
  parameter int RES_W   = RES_W_DEFAULT,
  parameter int LAT     = 3,
  parameter int C_STAGE = 2,
  parameter int TAG_W   = TAG_W_DEFAULT
) (
  input logic           clock,
  input logic           reset,
  mul_add_pipe_if.slave io
);
  if (RES_W > 2 * W) begin : g_bad_res_w
    $error("mul_add_pipe: RES_W must not exceed 2*W");
  end
  if (LAT < 2) begin : g_bad_lat
    $error("mul_add_pipe: LAT must be at least 2");
  end
  if (C_STAGE < 1 || C_STAGE > LAT - 1) begin : g_bad_c_stage
    $error("mul_add_pipe: C_STAGE must lie in 1..LAT-1");
  end
  if (W > EXT_W_MAX || RES_W > EXT_W_MAX) begin : g_bad_ext
    $error("mul_add_pipe: operand widths exceed EXT_W_MAX");
  end
  typedef struct packed {
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             is_signed;
    logic [TAG_W-1:0] tag;
  } op_t;
  typedef struct packed {
    logic [RES_W-1:0] sum;
    logic [TAG_W-1:0] tag;
  } res_t;
  logic             accept;
  logic [W-1:0]     a_hold;
  logic [W-1:0]     b_hold;
  logic [TAG_W:0]   s1_q;
  logic             op_v [1:C_STAGE];
  op_t              op_q [1:C_STAGE];
  logic             rs_v [C_STAGE:LAT];
  res_t             rs_q [C_STAGE:LAT];
  logic [RES_W-1:0] ea;
  logic [RES_W-1:0] eb;
  logic [RES_W-1:0] ec;
  assign accept = io.in_valid & ~io.stall & ~io.flush;
  // stage-1 operands live in the hold registers so a sequencer can reuse a or b;
  // they are untouched by flush and only change on an accepted op that latches them
  always_ff @(posedge clock) begin
    if (reset) begin
      a_hold <= '0;
      b_hold <= '0;
    end else if (accept) begin
      if (io.latch_a) a_hold <= io.a;
      if (io.latch_b) b_hold <= io.b;
    end
  end
  mul_pipe_stage #(.PW(TAG_W + 1)) u_s1 (
    .clock    (clock),
    .reset    (reset),
    .stall    (io.stall),
    .flush    (io.flush),
    .in_valid (io.in_valid),
    .in_data  ({io.is_signed, io.tag}),
    .out_valid(op_v[1]),
    .out_data (s1_q)
  );
  assign op_q[1] = {a_hold, b_hold, s1_q};
  for (genvar k = 2; k <= C_STAGE; k++) begin : g_op
    mul_pipe_stage #(.PW($bits(op_t))) u_st (
      .clock    (clock),
      .reset    (reset),
      .stall    (io.stall),
      .flush    (io.flush),
      .in_valid (op_v[k-1]),
      .in_data  (op_q[k-1]),
      .out_valid(op_v[k]),
      .out_data (op_q[k])
    );
  end
  // only the low RES_W bits of the 2W-bit sum are kept, and those depend only on the
  // low RES_W bits of the extended operands, so the arithmetic runs at RES_W
  assign ea = RES_W'(ext_operand(EXT_W_MAX'(op_q[C_STAGE].a), W, op_q[C_STAGE].is_signed));
  assign eb = RES_W'(ext_operand(EXT_W_MAX'(op_q[C_STAGE].b), W, op_q[C_STAGE].is_signed));
  assign ec = RES_W'(ext_operand(EXT_W_MAX'(io.c), RES_W, op_q[C_STAGE].is_signed));
  assign rs_v[C_STAGE] = op_v[C_STAGE];
  assign rs_q[C_STAGE] = '{sum: ea * eb + ec, tag: op_q[C_STAGE].tag};
  for (genvar k = C_STAGE + 1; k <= LAT; k++) begin : g_res
    mul_pipe_stage #(.PW($bits(res_t))) u_st (
      .clock    (clock),
      .reset    (reset),
      .stall    (io.stall),
      .flush    (io.flush),
      .in_valid (rs_v[k-1]),
      .in_data  (rs_q[k-1]),
      .out_valid(rs_v[k]),
      .out_data (rs_q[k])
    );
  end
  assign io.c_req     = op_v[C_STAGE];
  assign io.out_valid = rs_v[LAT];
  assign io.out_tag   = rs_q[LAT].tag;
  assign io.result    = rs_q[LAT].sum;
endmodule
